// File: rtl/fmul_issue.sv
// Issue/collect stage around the fixed-latency fmul_p1 core.
// Credit admission keeps the result FIFO from ever overflowing.
module fmul_issue #(
  parameter int TAG_W = 6,
  parameter int DEPTH = 4,
  parameter int LAT   = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_a,
  input  logic [31:0]      in_b,
  input  logic [TAG_W-1:0] in_tag,
  output logic [31:0]      x1,
  output logic [31:0]      x2,
  input  logic [31:0]      y,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_data,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_zero
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int SW = CW + $clog2(LAT + 1) + 1;

  logic                  fire_in;
  logic                  push;
  logic                  pop;

  logic [LAT-1:0]        pv_q;
  logic [TAG_W-1:0]      ptag_q [LAT];

  logic [31:0]           data_q [DEPTH];
  logic [TAG_W-1:0]      tag_q  [DEPTH];
  logic                  zero_q [DEPTH];

  logic [AW-1:0]         wr_q, wr_d;
  logic [AW-1:0]         rd_q, rd_d;
  logic [CW-1:0]         count_q, count_d;

  logic [SW-1:0]         inflight;
  logic [SW-1:0]         credit_used;

  assign x1 = in_a;
  assign x2 = in_b;

  assign fire_in = in_valid & in_ready;
  assign push    = pv_q[LAT-1];
  assign pop     = out_valid & out_ready;

  // Credit: queued results plus results still inside the core.
  always_comb begin
    inflight = '0;
    for (int i = 0; i < LAT; i++) begin
      inflight = inflight + SW'(pv_q[i]);
    end
    credit_used = SW'(count_q) + inflight;
    in_ready    = !rst && (credit_used < SW'(DEPTH));
  end

  // Tag pipe aligned with the core latency.
  always_ff @(posedge clk) begin
    if (rst) begin
      pv_q <= '0;
      for (int i = 0; i < LAT; i++) begin
        ptag_q[i] <= '0;
      end
    end else begin
      pv_q[0]   <= fire_in;
      ptag_q[0] <= in_tag;
      for (int i = 1; i < LAT; i++) begin
        pv_q[i]   <= pv_q[i-1];
        ptag_q[i] <= ptag_q[i-1];
      end
    end
  end

  // Pointer and occupancy next state.
  always_comb begin
    wr_d    = wr_q + AW'(push);
    rd_d    = rd_q + AW'(pop);
    count_d = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // FIFO control registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
    end else begin
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      count_q <= count_d;
    end
  end

  // FIFO storage; a push is never blocked.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        data_q[i] <= '0;
        tag_q[i]  <= '0;
        zero_q[i] <= 1'b0;
      end
    end else if (push) begin
      data_q[wr_q] <= y;
      tag_q[wr_q]  <= ptag_q[LAT-1];
      zero_q[wr_q] <= (y[30:23] == 8'd0);
    end
  end

  assign out_valid = (count_q != '0);
  assign out_data  = data_q[rd_q];
  assign out_tag   = tag_q[rd_q];
  assign out_zero  = zero_q[rd_q];

endmodule
